// File: rtl/viterbi_ctrl.sv
// Sequencing controller for a hard-decision Viterbi decoder: accepts one code symbol
// at a time, sweeps the shared branch-metric unit over all four codewords, strobes ACS,
// and hands the finished frame to traceback.
module viterbi_ctrl #(
    parameter int FRAME_LEN  = 8,
    parameter int data_width = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [data_width-1:0]     rx_data,
    input  logic                      rx_valid,
    output logic                      rx_ready,
    output logic [data_width-1:0]     bmu_rx,
    output logic [data_width-1:0]     bmu_trellis,
    input  logic [data_width-1:0]     bmu_metric,
    output logic [4*data_width-1:0]   bm_vec,
    output logic                      acs_en,
    output logic                      tb_start,
    input  logic                      tb_done,
    output logic [7:0]                sym_cnt,
    output logic                      busy,
    output logic                      done
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SYM,
        BM,
        ACS,
        TB,
        DONE
    } state_t;

    localparam logic [7:0] LAST_SYM = 8'(FRAME_LEN - 1);

    state_t          state;
    state_t          state_next;
    logic [1:0]      phase;

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            IDLE:     if (start)         state_next = WAIT_SYM;
            WAIT_SYM: if (rx_valid)      state_next = BM;
            BM:       if (phase == 2'd3) state_next = ACS;
            ACS:      state_next = (sym_cnt == LAST_SYM) ? TB : WAIT_SYM;
            TB:       if (tb_done)       state_next = DONE;
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Handshake and codeword select are pure decodes of the state register.
    assign rx_ready    = (state == WAIT_SYM);
    assign busy        = (state != IDLE);
    assign bmu_trellis = (state == BM) ? data_width'(phase) : '0;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            phase    <= 2'd0;
            sym_cnt  <= 8'd0;
            bm_vec   <= '0;
            bmu_rx   <= '0;
            acs_en   <= 1'b0;
            tb_start <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            phase    <= (state == BM) ? phase + 2'd1 : 2'd0;
            // Strobes are registered from the next state so they line up with it.
            acs_en   <= (state_next == ACS);
            tb_start <= (state == ACS) && (state_next == TB);
            done     <= (state_next == DONE);

            if (state == WAIT_SYM && rx_valid)
                bmu_rx <= rx_data;

            if (state == BM)
                bm_vec[{phase, 1'b0} +: data_width] <= bmu_metric;

            if (state == IDLE && start)
                sym_cnt <= 8'd0;
            else if (state == ACS && state_next == WAIT_SYM)
                sym_cnt <= sym_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_viterbi_ctrl.sv
// Directed bench for viterbi_ctrl: a 2-symbol frame instance and a 255-symbol frame
// instance share stimulus; each sees an ideal matching-bit-count branch-metric unit.
module tb_viterbi_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, rx_valid, tb_done;
    logic [1:0] rx_data;

    logic       rx_ready_a, acs_en_a, tb_start_a, busy_a, done_a;
    logic [1:0] bmu_rx_a, bmu_trellis_a, bmu_metric_a;
    logic [7:0] bm_vec_a, sym_cnt_a;

    logic       rx_ready_b, acs_en_b, tb_start_b, busy_b, done_b;
    logic [1:0] bmu_rx_b, bmu_trellis_b, bmu_metric_b;
    logic [7:0] bm_vec_b, sym_cnt_b;

    int n_checks = 0;
    int n_fail   = 0;
    int n_tbs_a  = 0;

    always #5 clk = ~clk;

    function automatic logic [1:0] ideal_metric(input logic [1:0] rx, input logic [1:0] cw);
        return 2'(rx[1] == cw[1]) + 2'(rx[0] == cw[0]);
    endfunction

    assign bmu_metric_a = ideal_metric(bmu_rx_a, bmu_trellis_a);
    assign bmu_metric_b = ideal_metric(bmu_rx_b, bmu_trellis_b);

    viterbi_ctrl #(.FRAME_LEN(2), .data_width(2)) dut_a (
        .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready_a), .bmu_rx(bmu_rx_a), .bmu_trellis(bmu_trellis_a),
        .bmu_metric(bmu_metric_a), .bm_vec(bm_vec_a), .acs_en(acs_en_a),
        .tb_start(tb_start_a), .tb_done(tb_done), .sym_cnt(sym_cnt_a),
        .busy(busy_a), .done(done_a)
    );

    viterbi_ctrl #(.FRAME_LEN(255), .data_width(2)) dut_b (
        .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready_b), .bmu_rx(bmu_rx_b), .bmu_trellis(bmu_trellis_b),
        .bmu_metric(bmu_metric_b), .bm_vec(bm_vec_b), .acs_en(acs_en_b),
        .tb_start(tb_start_b), .tb_done(tb_done), .sym_cnt(sym_cnt_b),
        .busy(busy_b), .done(done_b)
    );

    always @(negedge clk) if (tb_start_a === 1'b1) n_tbs_a++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_a(input string pfx);
        check({pfx, "_sym_cnt"},     32'(sym_cnt_a),     32'd0);
        check({pfx, "_bm_vec"},      32'(bm_vec_a),      32'd0);
        check({pfx, "_bmu_rx"},      32'(bmu_rx_a),      32'd0);
        check({pfx, "_bmu_trellis"}, 32'(bmu_trellis_a), 32'd0);
        check({pfx, "_acs_en"},      32'(acs_en_a),      32'd0);
        check({pfx, "_tb_start"},    32'(tb_start_a),    32'd0);
        check({pfx, "_done"},        32'(done_a),        32'd0);
        check({pfx, "_busy"},        32'(busy_a),        32'd0);
        check({pfx, "_rx_ready"},    32'(rx_ready_a),    32'd0);
    endtask

    // Presents one symbol to instance a from WAIT_SYM and walks it through BM into ACS.
    task automatic sym_a(input logic [1:0] sym, input logic [7:0] exp_bm, input logic pulse_start);
        rx_data  = sym;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        check("bm_bmu_rx", 32'(bmu_rx_a), 32'(sym));
        for (int k = 0; k < 4; k++) begin
            check("bm_trellis", 32'(bmu_trellis_a), 32'(k));
            check("bm_rx_ready", 32'(rx_ready_a), 32'd0);
            check("bm_acs_en", 32'(acs_en_a), 32'd0);
            if (pulse_start && k == 1) start = 1'b1;
            tick();
            start = 1'b0;
        end
        check("acs_en", 32'(acs_en_a), 32'd1);
        check("acs_bm_vec", 32'(bm_vec_a), 32'(exp_bm));
        check("acs_trellis", 32'(bmu_trellis_a), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n_acs;
        int  got_tb;
        int  wrapped;
        int  seen_bad;
        logic [7:0] prev;

        rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 2'b00; tb_done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_reset_a("por");

        // Reset wins over start in the same cycle.
        rst = 1'b1; start = 1'b1;
        tick();
        check("rst_start_busy", 32'(busy_a), 32'd0);
        check("rst_start_rx_ready", 32'(rx_ready_a), 32'd0);
        rst = 1'b0; start = 1'b0;
        tick();
        check("idle_hold_busy", 32'(busy_a), 32'd0);

        // Nominal 2-symbol frame with a stalled input and stray tb_done first.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_rx_ready", 32'(rx_ready_a), 32'd1);
        check("start_busy", 32'(busy_a), 32'd1);
        check("start_sym_cnt", 32'(sym_cnt_a), 32'd0);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) tb_done = 1'b1;
            tick();
            tb_done = 1'b0;
            check("stall_rx_ready", 32'(rx_ready_a), 32'd1);
            check("stall_trellis", 32'(bmu_trellis_a), 32'd0);
            check("stall_sym_cnt", 32'(sym_cnt_a), 32'd0);
        end

        sym_a(2'b10, 8'b01_10_00_01, 1'b1);
        tick();
        check("sym0_acs_off", 32'(acs_en_a), 32'd0);
        check("sym0_rx_ready", 32'(rx_ready_a), 32'd1);
        check("sym0_sym_cnt", 32'(sym_cnt_a), 32'd1);
        check("sym0_bm_stable", 32'(bm_vec_a), 32'h61);

        sym_a(2'b01, 8'b01_00_10_01, 1'b0);
        tick();
        check("tb_start_pulse", 32'(tb_start_a), 32'd1);
        check("tb_rx_ready", 32'(rx_ready_a), 32'd0);
        check("tb_sym_cnt", 32'(sym_cnt_a), 32'd1);
        tick();
        check("tb1_tb_start", 32'(tb_start_a), 32'd0);
        check("tb1_done", 32'(done_a), 32'd0);
        tick();
        check("tb2_tb_start", 32'(tb_start_a), 32'd0);
        tick();
        check("tb3_done", 32'(done_a), 32'd0);
        tb_done = 1'b1;
        tick();
        tb_done = 1'b0;
        check("done_at_tb_plus4", 32'(done_a), 32'd1);
        check("done_busy", 32'(busy_a), 32'd1);
        tick();
        check("post_done", 32'(done_a), 32'd0);
        check("post_done_busy", 32'(busy_a), 32'd0);
        check("post_done_sym_cnt", 32'(sym_cnt_a), 32'd1);
        check("tb_start_count", 32'(n_tbs_a), 32'd1);

        // Reset in BM phase 2 discards the partial frame.
        start = 1'b1;
        tick();
        start = 1'b0;
        rx_data = 2'b11; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        tick();
        tick();
        check("mid_bm_phase2", 32'(bmu_trellis_a), 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_a("mid_bm");
        seen_bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (acs_en_a || done_a || busy_a) seen_bad = 1;
        end
        check("after_rst_quiet", 32'(seen_bad), 32'd0);

        // 255-symbol frame streamed back to back on instance b.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("long_rx_ready", 32'(rx_ready_b), 32'd1);
        check("long_sym_cnt0", 32'(sym_cnt_b), 32'd0);
        n_acs = 0; got_tb = 0; wrapped = 0; prev = 8'd0;
        rx_valid = 1'b1;
        for (int cyc = 0; cyc < 255 * 6 + 20; cyc++) begin
            rx_data = 2'(cyc);
            tick();
            if (acs_en_b) n_acs++;
            if (sym_cnt_b < prev) wrapped = 1;
            prev = sym_cnt_b;
            if (tb_start_b) begin
                got_tb = 1;
                break;
            end
        end
        rx_valid = 1'b0;
        check("long_reached_tb", 32'(got_tb), 32'd1);
        check("long_acs_count", 32'(n_acs), 32'd255);
        check("long_sym_cnt_last", 32'(sym_cnt_b), 32'd254);
        check("long_no_wrap", 32'(wrapped), 32'd0);
        tb_done = 1'b1;
        tick();
        tb_done = 1'b0;
        check("long_done_immediate", 32'(done_b), 32'd1);
        check("long_done_sym_cnt", 32'(sym_cnt_b), 32'd254);
        tick();
        check("long_idle_busy", 32'(busy_b), 32'd0);
        check("long_idle_done", 32'(done_b), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
